// File: rtl/prio_seg_pkg.sv
// Shared constants for the priority-encoder / 7-segment scan tile.
// Segment codes are gfedcba, active high. Digit select codes are one-hot
// enables for the two display digits.
package prio_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIGIT_OFF  = 2'b00;
  localparam logic [1:0] DIGIT_ONES = 2'b01;
  localparam logic [1:0] DIGIT_TENS = 2'b10;

  // Which digit the scan is currently showing.
  typedef enum logic {
    PhaseOnes = 1'b0,
    PhaseTens = 1'b1
  } phase_e;

endpackage

// File: rtl/prio_enc_7seg_scan_if.sv
// Pin-side bundle of the priority-encoder / 7-segment scan tile.
//   data       : raw inputs, bit WIDTH-1 has highest priority
//   mode_latch : 0 = live, 1 = peak-hold
//   clear      : synchronous clear of the held/current index
//   segments   : gfedcba segment code, active high
//   digit_sel  : one-hot digit enable (01 ones, 10 tens)
//   none       : high when no index is valid (dp pin)
//   index      : registered index, test/debug
// master drives the inputs (tile pins / bench), slave is the tile itself.
interface prio_enc_7seg_scan_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned IDXW = $clog2(WIDTH);

  logic [WIDTH-1:0] data;
  logic             mode_latch;
  logic             clear;
  logic [6:0]       segments;
  logic [1:0]       digit_sel;
  logic             none;
  logic [IDXW-1:0]  index;

  modport master (
    output data, mode_latch, clear,
    input  segments, digit_sel, none, index
  );

  modport slave (
    input  data, mode_latch, clear,
    output segments, digit_sel, none, index
  );
endinterface

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to 7-segment (gfedcba) decoder.
//   bcd_i : 4-bit digit; 10..15 decode to blank
//   seg_o : segment code, active high
module seg7_bcd_decode
  import prio_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/prio_enc_7seg_scan.sv
// Priority encoder with time-multiplexed two-digit 7-segment display.
// Synchronises WIDTH raw inputs, registers the index of the highest set bit
// (live or peak-hold), and scans its decimal value over two digits, each
// shown for SCAN_DIV cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of prio_enc_7seg_scan_if (inputs, display, debug)
module prio_enc_7seg_scan
  import prio_seg_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prio_enc_7seg_scan_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [IDXW-1:0]  hi, idx_q, idx_d;
  logic             nz, none_q, none_d;
  logic [CntW-1:0]  cnt_q;
  phase_e           phase_q;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dsel_q, dsel_d;
  logic             none_out_q;

  int unsigned      idx_wide;
  logic [3:0]       tens, ones, digit;
  logic [6:0]       digit_seg;
  logic             blank;

  // Highest set bit of the synchronised input; later bits overwrite earlier.
  always_comb begin
    hi = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i]) hi = IDXW'(i);
    end
    nz = |sync2_q;
  end

  // clear beats everything; latch mode only moves on a new or higher index.
  always_comb begin
    idx_d  = idx_q;
    none_d = none_q;
    if (bus.clear) begin
      idx_d  = '0;
      none_d = 1'b1;
    end else if (!bus.mode_latch) begin
      idx_d  = hi;
      none_d = ~nz;
    end else if (nz && (none_q || hi > idx_q)) begin
      idx_d  = hi;
      none_d = 1'b0;
    end
  end

  always_comb begin
    idx_wide = 32'(idx_q);
    tens     = 4'(idx_wide / 10);
    ones     = 4'(idx_wide % 10);
    digit    = (phase_q == PhaseTens) ? tens : ones;
  end

  seg7_bcd_decode u_dec (
    .bcd_i (digit),
    .seg_o (digit_seg)
  );

  // Blank the whole display when nothing is valid, and a leading-zero tens digit.
  always_comb begin
    blank  = none_q || ((phase_q == PhaseTens) && (tens == 4'd0));
    seg_d  = blank ? SEG_BLANK : digit_seg;
    dsel_d = (phase_q == PhaseTens) ? DIGIT_TENS : DIGIT_ONES;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      idx_q      <= '0;
      none_q     <= 1'b1;
      cnt_q      <= '0;
      phase_q    <= PhaseOnes;
      seg_q      <= SEG_BLANK;
      dsel_q     <= DIGIT_OFF;
      none_out_q <= 1'b1;
    end else begin
      sync1_q    <= bus.data;
      sync2_q    <= sync1_q;
      idx_q      <= idx_d;
      none_q     <= none_d;
      seg_q      <= seg_d;
      dsel_q     <= dsel_d;
      none_out_q <= none_q;
      if (cnt_q == CntW'(SCAN_DIV - 1)) begin
        cnt_q   <= '0;
        phase_q <= (phase_q == PhaseOnes) ? PhaseTens : PhaseOnes;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign bus.segments  = seg_q;
  assign bus.digit_sel = dsel_q;
  assign bus.none      = none_out_q;
  assign bus.index     = idx_q;

endmodule

// File: tb/tb_prio_enc_7seg_scan.sv
// Scoreboard bench for prio_enc_7seg_scan (WIDTH=16, SCAN_DIV=4).
// The driver advances a reference model per clock edge and queues the
// expected outputs; a negedge monitor pops and compares.
module tb_prio_enc_7seg_scan;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   clk_run = 1'b0;

  prio_enc_7seg_scan_if #(.WIDTH(WIDTH)) bus ();

  prio_enc_7seg_scan #(
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] index;
    logic       none;
    logic [6:0] segments;
    logic [1:0] digit_sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int          edge_n;
  int          m_idx;
  bit          m_none;
  logic [15:0] hist[$];
  logic [15:0] cur_data;
  bit          cur_mode;
  bit          cur_clear;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb_index(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [6:0] shown(input int idx, input bit none, input bit tens_phase);
    if (none) return 7'h00;
    if (tens_phase) return (idx / 10 == 0) ? 7'h00 : seg_tbl[idx / 10];
    return seg_tbl[idx % 10];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    edge_n = 0;
    m_idx  = 0;
    m_none = 1'b1;
    hist.delete();
    hist.push_back(16'h0);
    hist.push_back(16'h0);
  endtask

  // One rising edge: inputs cur_* were present before it.
  task automatic model_edge();
    exp_t        e;
    logic [15:0] s;
    bit          ph;
    int          hi;
    edge_n++;
    hist.push_back(cur_data);
    s = hist[hist.size() - 3];   // data seen by the encoder two edges late
    while (hist.size() > 2) void'(hist.pop_front());
    ph = (((edge_n - 1) / SCAN_DIV) % 2) == 1;
    e.segments  = shown(m_idx, m_none, ph);
    e.none      = m_none;
    e.digit_sel = ph ? 2'b10 : 2'b01;
    hi = msb_index(s);
    if (cur_clear) begin
      m_idx = 0; m_none = 1'b1;
    end else if (!cur_mode) begin
      m_idx = hi; m_none = (s == 16'h0);
    end else if (s != 16'h0 && (m_none || hi > m_idx)) begin
      m_idx = hi; m_none = 1'b0;
    end
    e.index = 4'(m_idx);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [15:0] d, input bit mode, input bit clr);
    @(posedge clk);
    #1;
    model_edge();
    cur_data       = d;
    cur_mode       = mode;
    cur_clear      = clr;
    bus.data       = d;
    bus.mode_latch = mode;
    bus.clear      = clr;
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "_segments"},  int'(bus.segments),  0);
    cmp({tag, "_digit_sel"}, int'(bus.digit_sel), 0);
    cmp({tag, "_none"},      int'(bus.none),      1);
    cmp({tag, "_index"},     int'(bus.index),     0);
  endtask

  // Called at posedge+1: drop reset mid-cycle, check immediately and across an edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset(tag);
    @(posedge clk);
    #1;
    check_reset({tag, "_hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_pattern();
    int k = $urandom_range(0, 16);
    int v;
    if (k == 16) return 16'h0;
    v = int'($urandom) & ((1 << k) - 1);
    return 16'(v | (1 << k));
  endfunction

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("index",     int'(bus.index),     int'(e.index));
      cmp("none",      int'(bus.none),      int'(e.none));
      cmp("segments",  int'(bus.segments),  int'(e.segments));
      cmp("digit_sel", int'(bus.digit_sel), int'(e.digit_sel));
    end
  end

  initial begin
    logic [15:0] d;
    bit          mode;
    bus.data       = '0;
    bus.mode_latch = 1'b0;
    bus.clear      = 1'b0;
    cur_data  = '0;
    cur_mode  = 1'b0;
    cur_clear = 1'b0;
    model_reset();

    // Power-on reset with no clock running.
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    clk_run = 1'b1;
    @(posedge clk);
    #1 check_reset("por_clocked");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (16) step(16'h0000, 1'b0, 1'b0);
    repeat (12) step(16'h0421, 1'b0, 1'b0);
    repeat (12) step(16'h0080, 1'b0, 1'b0);

    // Peak hold, then clear while a lower value is present.
    repeat (8) step(16'h0100, 1'b1, 1'b0);
    repeat (8) step(16'h0004, 1'b1, 1'b0);
    repeat (8) step(16'h8000, 1'b1, 1'b0);
    repeat (4) step(16'h0004, 1'b1, 1'b0);
    step(16'h0004, 1'b1, 1'b1);
    repeat (8) step(16'h0004, 1'b1, 1'b0);

    mode = 1'b0;
    repeat (150) begin
      d = rand_pattern();
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      repeat ($urandom_range(1, 6)) step(d, mode, $urandom_range(0, 15) == 0);
    end

    // Reset landing in the tens phase with counter 2 and index 15.
    step(16'h8000, 1'b0, 1'b0);
    async_reset("async_a");
    repeat (6) step(16'h8000, 1'b0, 1'b0);
    async_reset("async_b");
    repeat (12) step(16'h8000, 1'b0, 1'b0);

    repeat (60) begin
      d = rand_pattern();
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      repeat ($urandom_range(1, 5)) step(d, mode, $urandom_range(0, 11) == 0);
    end

    @(negedge clk);
    #1;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_7seg_scan.md
Name: prio_enc_7seg_scan

Overview:
Parametrised successor to the team's 8-bit priority encoder with 7-segment output. It synchronises a WIDTH-bit input and finds the index of the most significant set bit. It shows that index as a two-digit decimal number on a time-multiplexed 7-segment display, with an optional latch mode that holds the peak index. It sits directly between the user input pins and the display output pins of the tile.

Parameters:
WIDTH, 16, number of data inputs; legal range 2..99, so the index is at most 98 and fits two decimal digits.
SCAN_DIV, 1024, clock cycles each digit is shown before the scan switches; legal minimum 2.
IDXW, $clog2(WIDTH), width of the index; derived, never overridden.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data  in  WIDTH  raw data inputs; bit WIDTH-1 has highest priority
mode_latch  in  1  0 = live mode, 1 = latch (peak-hold) mode
clear  in  1  synchronous clear of the held/current index
segments  out  7  segment code, bit order gfedcba, active high
digit_sel  out  2  one-hot digit enable: 01 = ones digit, 10 = tens digit
none  out  1  high when no index is held/valid (drives the dp pin)
index  out  IDXW  registered index, for test/debug

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - sync flops = 0, idx_q = 0, none_q = 1, scan counter = 0, phase = 0.
  - Outputs: segments = 0, digit_sel = 00, none = 1, index = 0.
- Sync: data passes through a 2-flop synchroniser. The encode stage registers idx_q and none_q. A data change is visible on index/none 3 cycles later.
- Encode: hi = highest i with sync[i] = 1; nz = any bit set.
- Live mode (mode_latch = 0): each cycle idx_q <= hi and none_q <= ~nz.
- Latch mode (mode_latch = 1): update idx_q <= hi and none_q <= 0 only if nz && (none_q || hi > idx_q); otherwise hold.
- clear: forces idx_q <= 0, none_q <= 1 that cycle and overrides any update. Capture resumes the next cycle; in live mode the live value reappears one cycle after clear deasserts.
- Mode change:
  - Live -> latch: the held value starts from the current idx_q.
  - Latch -> live: follows hi from the next cycle.
- BCD conversion: tens = idx_q / 10, ones = idx_q % 10, combinational on idx_q, no divider state.
- Scan counter:
  - Counts 0..SCAN_DIV-1; on wrap to 0, phase toggles.
  - Phase 0 selects ones, phase 1 selects tens.
  - The first full phase-0 window starts at reset release.
- Output register: segments, digit_sel and none are registered, updating one cycle after phase/idx_q change.
  - digit_sel = 01 in phase 0 and 10 in phase 1, always one-hot after the first clock.
  - Tens leading-zero blanking: tens == 0 in phase 1 -> segments = 0000000.
  - none_q = 1 -> segments = 0000000 in both phases and none = 1; otherwise none = 0.
- Segment codes (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10..15 give blank.
- Reset mid-scan: all state returns to its reset value immediately; no partial digit is driven.

Decomposition:
- Shared package prio_seg_pkg holds the SEG_0..SEG_9 and SEG_BLANK 7-bit constants and the DIGIT_ONES/DIGIT_TENS select codes.
- One sub-module, seg7_bcd_decode: combinational 4-bit BCD to gfedcba; values 10..15 give blank.

Test Plan:
- Reset (WIDTH=16, SCAN_DIV=4 throughout): hold rst_n low with no clock -> segments=0000000, digit_sel=00, none=1, index=0.
- Empty input: data=16'h0000 for 16 cycles -> none=1, segments=0000000 in both phases, digit_sel alternates 01/10 every 4 cycles.
- Two-digit value: data=16'h0421 -> index=10 after 3 cycles; ones phase segments=0111111 with digit_sel=01; tens phase segments=0000110 with digit_sel=10; none=0.
- Leading-zero blanking: data=16'h0080 -> index=7; ones phase segments=0000111; tens phase segments=0000000.
- Latch mode: mode_latch=1 with data=16'h0100 -> index 8. Then data=16'h0004 -> index stays 8. Then data=16'h8000 -> index 15. Then clear=1 for one cycle while data=16'h0004 -> none=1 and index 0, then index 2 and none=0 on the following cycle.
- Asynchronous reset mid-operation: rst_n low mid-scan (phase 1, counter=2, index=15) -> outputs return to reset values before the next clock edge. After release, the scan restarts with digit_sel=01 for 4 cycles once data has propagated.
